real_delay_line: RTL and testbench



---
 rtl/real_delay_line.sv | 86 ++++++++
 tb/tb_real_delay_line.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/real_delay_line.sv
// Multi-channel real-valued delay line indexed by accepted samples.
// Per-channel history lives in a circular buffer; all channels share one write pointer and fill count.
module real_delay_line #(
  parameter int  N_CH  = 2,
  parameter int  DEPTH = 16,
  parameter int  DW    = $clog2(DEPTH + 1),
  parameter real scale = 1.0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  real           in [N_CH],
  input  logic [DW-1:0] dly,
  input  logic          flush,
  output real           out [N_CH],
  output logic          out_valid,
  output logic          primed
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  real           mem [DEPTH][N_CH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [DW-1:0] fill;
  logic [DW-1:0] fill_next;
  logic [DW-1:0] d_eff;
  logic [PW-1:0] rd_idx;
  logic          accept;
  logic          hit;
  int            rd_i;

  assign accept = in_valid && !flush;
  assign d_eff  = (dly > DW'(DEPTH)) ? DW'(DEPTH) : dly;
  assign hit    = accept && (fill >= d_eff);

  // Oldest slot for d=DEPTH is the one about to be overwritten; the read
  // happens from the pre-edge contents, so it still returns x[n-DEPTH].
  always_comb begin
    rd_i = int'(wr_ptr) + DEPTH - int'(d_eff);
    if (rd_i >= DEPTH) rd_i = rd_i - DEPTH;
    rd_idx = PW'(rd_i);
  end

  always_comb begin
    wr_ptr_next = wr_ptr;
    fill_next   = fill;
    if (flush) begin
      wr_ptr_next = '0;
      fill_next   = '0;
    end else if (in_valid) begin
      wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (fill != DW'(DEPTH)) fill_next = fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
      for (int c = 0; c < N_CH; c++) out[c] <= 0.0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      fill      <= fill_next;
      out_valid <= hit;
      primed    <= (fill_next >= d_eff);
      if (hit) begin
        for (int c = 0; c < N_CH; c++) begin
          // d=0 bypasses the buffer: the slot at wr_ptr holds stale data.
          if (d_eff == '0) out[c] <= scale * in[c];
          else             out[c] <= scale * mem[rd_idx][c];
        end
      end
    end
  end

  // History is intentionally not cleared; entries beyond fill are never read.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int c = 0; c < N_CH; c++) mem[wr_ptr][c] <= in[c];
    end
  end

endmodule

// File: tb/tb_real_delay_line.sv
// Directed bench for real_delay_line: reset, delay, clamp, wrap, dly change, flush, gaps.
module tb_real_delay_line;
  localparam int N_CH  = 2;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          flush;
  logic [DW-1:0] dly;
  real           in [N_CH];
  real           out [N_CH];
  real           out2 [N_CH];
  logic          out_valid, primed, out_valid2, primed2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  real_delay_line #(.N_CH(N_CH), .DEPTH(DEPTH), .scale(1.0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .dly(dly), .flush(flush),
    .out(out), .out_valid(out_valid), .primed(primed)
  );

  real_delay_line #(.N_CH(N_CH), .DEPTH(DEPTH), .scale(2.0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .dly(dly), .flush(flush),
    .out(out2), .out_valid(out_valid2), .primed(primed2)
  );

  task automatic drive(input logic v, input logic f, input real a, input real b);
    @(negedge clk);
    in_valid = v;
    flush    = f;
    in[0]    = a;
    in[1]    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in[0] = 0.0; in[1] = 0.0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < N_CH; c++) begin
      n_cmp++;
      if (out[c] != 0.0) begin
        n_err++; $display("FAIL reset_out[%0d] got %f want 0.0", c, out[c]);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++;
    if (primed !== 1'b0) begin n_err++; $display("FAIL reset_primed got %b want 0", primed); end
  endtask

  task automatic test_basic();
    real e;
    do_reset();
    dly = 2;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, real'(k), real'(k) * 10.0);
      e = (k >= 3) ? real'(k - 2) : 0.0;
      n_cmp++;
      if (out_valid !== (k >= 3)) begin
        n_err++; $display("FAIL basic_valid k=%0d got %b want %b", k, out_valid, (k >= 3));
      end
      n_cmp++;
      if (out[0] != e) begin n_err++; $display("FAIL basic_out0 k=%0d got %f want %f", k, out[0], e); end
      n_cmp++;
      if (out[1] != e * 10.0) begin
        n_err++; $display("FAIL basic_out1 k=%0d got %f want %f", k, out[1], e * 10.0);
      end
      n_cmp++;
      if (primed !== (k >= 2)) begin
        n_err++; $display("FAIL basic_primed k=%0d got %b want %b", k, primed, (k >= 2));
      end
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    dly = 0;
    drive(1'b1, 1'b0, 1.5, 0.25);
    n_cmp++;
    if (out_valid2 !== 1'b1) begin n_err++; $display("FAIL pass_valid got %b want 1", out_valid2); end
    n_cmp++;
    if (out2[1] != 0.5) begin n_err++; $display("FAIL pass_out1 got %f want 0.5", out2[1]); end
    n_cmp++;
    if (out2[0] != 3.0) begin n_err++; $display("FAIL pass_out0 got %f want 3.0", out2[0]); end
    n_cmp++;
    if (primed2 !== 1'b1) begin n_err++; $display("FAIL pass_primed got %b want 1", primed2); end
    drive(1'b0, 1'b0, 9.0, 9.0);
    n_cmp++;
    if (out_valid2 !== 1'b0) begin n_err++; $display("FAIL pass_idle_valid got %b want 0", out_valid2); end
    n_cmp++;
    if (out2[1] != 0.5) begin n_err++; $display("FAIL pass_hold got %f want 0.5", out2[1]); end
  endtask

  // Leaves fill=4 with x[0..9] = 1..10 for the dly-change test.
  task automatic test_clamp();
    do_reset();
    dly = 7;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b0, real'(k), -real'(k));
      n_cmp++;
      if (out_valid !== (k >= 5)) begin
        n_err++; $display("FAIL clamp_valid k=%0d got %b want %b", k, out_valid, (k >= 5));
      end
      if (k >= 5) begin
        n_cmp++;
        if (out[0] != real'(k - 4)) begin
          n_err++; $display("FAIL clamp_out0 k=%0d got %f want %f", k, out[0], real'(k - 4));
        end
        n_cmp++;
        if (out[1] != -real'(k - 4)) begin
          n_err++; $display("FAIL clamp_out1 k=%0d got %f want %f", k, out[1], -real'(k - 4));
        end
      end
    end
  endtask

  task automatic test_dly_change();
    logic [DW-1:0] dl [3] = '{3, 1, 4};
    real           ex [3] = '{8.0, 11.0, 9.0};
    for (int i = 0; i < 3; i++) begin
      dly = dl[i];
      drive(1'b1, 1'b0, real'(11 + i), 0.0);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL dlychg_valid i=%0d got %b want 1", i, out_valid); end
      n_cmp++;
      if (out[0] != ex[i]) begin
        n_err++; $display("FAIL dlychg_out i=%0d got %f want %f", i, out[0], ex[i]);
      end
    end
  endtask

  // Runs right after test_dly_change, so out[0] is 9.0 going in.
  task automatic test_flush();
    real vals [3] = '{9.0, 8.0, 7.0};
    dly = 1;
    drive(1'b1, 1'b1, 100.0, 100.0);
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
    n_cmp++;
    if (primed !== 1'b0) begin n_err++; $display("FAIL flush_primed got %b want 0", primed); end
    n_cmp++;
    if (out[0] != 9.0) begin n_err++; $display("FAIL flush_hold got %f want 9.0", out[0]); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, vals[k], vals[k] + 0.5);
      n_cmp++;
      if (out_valid !== (k >= 1)) begin
        n_err++; $display("FAIL flush_seq_valid k=%0d got %b want %b", k, out_valid, (k >= 1));
      end
      if (k >= 1) begin
        n_cmp++;
        if (out[0] != vals[k - 1]) begin
          n_err++; $display("FAIL flush_seq_out k=%0d got %f want %f", k, out[0], vals[k - 1]);
        end
        n_cmp++;
        if (out[1] != vals[k - 1] + 0.5) begin
          n_err++; $display("FAIL flush_seq_out1 k=%0d got %f want %f", k, out[1], vals[k - 1] + 0.5);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic v  [5] = '{1, 0, 0, 1, 1};
    real  iv [5] = '{10.0, 55.0, 66.0, 20.0, 30.0};
    logic ev [5] = '{0, 0, 0, 1, 1};
    real  eo [5] = '{0.0, 0.0, 0.0, 10.0, 20.0};
    do_reset();
    dly = 1;
    for (int k = 0; k < 5; k++) begin
      drive(v[k], 1'b0, iv[k], 0.0);
      n_cmp++;
      if (out_valid !== ev[k]) begin
        n_err++; $display("FAIL gaps_valid k=%0d got %b want %b", k, out_valid, ev[k]);
      end
      n_cmp++;
      if (out[0] != eo[k]) begin n_err++; $display("FAIL gaps_out k=%0d got %f want %f", k, out[0], eo[k]); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; dly = '0; in[0] = 0.0; in[1] = 0.0;
    test_reset();
    test_basic();
    test_passthrough();
    test_clamp();
    test_dly_change();
    test_flush();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
